demux8to1_collect_n: RTL

//   Write-side counterpart of the 8:1 read mux. It takes a stream of n-bit words, one per handshake,
//   and steers each word into one of 8 slot registers in order 0..7.

---
 rtl/demux_collect_pkg.sv | 13 +
 rtl/reg_en_n.sv | 21 ++
 rtl/demux8to1_collect_n.sv | 96 +++++++++
 3 files changed

// File: rtl/demux_collect_pkg.sv
// Shared types and sizes for the serial-to-frame collector.
package demux_collect_pkg;

    // Slot index width and slot count; the count is always 2**ADDRESS.
    localparam int unsigned ADDRESS = 3;
    localparam int unsigned M       = 8;

    typedef enum logic {
        FILL,
        FULL
    } collect_state_t;

endpackage

// File: rtl/reg_en_n.sv
// n-bit register with write enable and asynchronous active-low reset to zero.
module reg_en_n #(
    parameter int unsigned n = 4
) (
    input  logic [n-1:0] d,
    input  logic         en,
    input  logic         clk_i,
    input  logic         rst_ni,
    output logic [n-1:0] q
);

    // Load d when enabled, clear on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/demux8to1_collect_n.sv
// Packs a stream of n-bit words into an 8-slot frame and presents it with valid_o.
module demux8to1_collect_n
    import demux_collect_pkg::*;
#(
    parameter int unsigned n = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic [n-1:0]       data_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic [n-1:0]       data_o [0:M-1],
    output logic               valid_o,
    input  logic               ready_i,
    output logic [ADDRESS:0]   count_o
);

    localparam int unsigned CW = ADDRESS + 1;

    collect_state_t r_state;
    collect_state_t w_state_d;
    logic [CW-1:0]  r_count;
    logic [CW-1:0]  w_count_d;
    logic           w_accept;
    logic           w_write;
    logic [M-1:0]   w_slot_en;

    // FULL with ready_i hands the frame off, so a word can be taken the same cycle.
    assign ready_o  = (r_state == FILL) | ((r_state == FULL) & ready_i);
    assign w_accept = valid_i & ready_o;
    assign w_write  = w_accept & ~flush_i;
    assign valid_o  = (r_state == FULL);
    assign count_o  = r_count;

    // Slot index wraps naturally: count==8 in FULL addresses slot 0 for the handoff word.
    genvar g;
    generate
        for (g = 0; g < M; g++) begin : g_slot
            assign w_slot_en[g] = w_write & (r_count[ADDRESS-1:0] == ADDRESS'(g));

            reg_en_n #(
                .n(n)
            ) u_slot (
                .d     (data_i),
                .en    (w_slot_en[g]),
                .clk_i (clk_i),
                .rst_ni(rst_ni),
                .q     (data_o[g])
            );
        end
    endgenerate

    // State and fill count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= FILL;
            r_count <= '0;
        end else begin
            r_state <= w_state_d;
            r_count <= w_count_d;
        end
    end

    // Next-state and count logic; flush overrides everything.
    always_comb begin
        w_state_d = r_state;
        w_count_d = r_count;
        if (flush_i) begin
            w_state_d = FILL;
            w_count_d = '0;
        end else begin
            unique case (r_state)
                FILL: begin
                    if (w_accept) begin
                        w_count_d = r_count + CW'(1);
                        if (r_count == CW'(M - 1)) begin
                            w_state_d = FULL;
                        end
                    end
                end
                FULL: begin
                    if (ready_i) begin
                        w_state_d = FILL;
                        w_count_d = valid_i ? CW'(1) : '0;
                    end
                end
                default: begin
                    w_state_d = FILL;
                    w_count_d = '0;
                end
            endcase
        end
    end

endmodule
